// File: rtl/stream_demux_pkg.sv
// Shared defaults and the select range helper for the stream demultiplexer.
package stream_demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 4;
  localparam int ERRW_DEF  = 8;

  function automatic logic sel_ok(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice; a load always wins over a drain.
module stream_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/stream_demux.sv
// Valid/ready demultiplexer: steers each input word to the channel named by
// in_sel; out-of-range selects are accepted, dropped and counted.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int N     = N_DEF,
  parameter  int ERRW  = ERRW_DEF,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [ERRW-1:0]    err_cnt
);

  logic            sel_in_range;
  logic [N-1:0]    load;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  // A full channel only blocks the input while in_sel points at it.
  always_comb begin
    sel_in_range = sel_ok(32'(in_sel), N);
    in_ready     = 1'b1;
    load         = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SELW'(k)) begin
        in_ready = ~out_valid[k] | out_ready[k];
      end
    end
    for (int k = 0; k < N; k++) begin
      load[k] = in_valid & in_ready & (in_sel == SELW'(k));
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && !sel_in_range && (err_cnt_q != {ERRW{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

  for (genvar g = 0; g < N; g++) begin : g_chan
    stream_reg_slice #(
      .WIDTH (WIDTH)
    ) u_slice (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .d     (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .q     (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance and a 3-channel instance
// checked every cycle against per-channel queues of accepted words.
module tb_stream_demux;

  logic        clk, rst;
  logic        in_valid  [2];
  logic [1:0]  in_sel    [2];
  logic [7:0]  in_data   [2];
  logic [3:0]  out_ready [2];
  logic        rdy_a, rdy_b;
  logic [3:0]  ova;
  logic [2:0]  ovb;
  logic [31:0] oda;
  logic [23:0] odb;
  logic [7:0]  erra, errb;

  logic        ir  [2];
  logic [3:0]  ov  [2];
  logic [31:0] od  [2];
  logic [7:0]  err [2];

  stream_demux #(.WIDTH(8), .N(4), .ERRW(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy_a),
    .in_sel(in_sel[0]), .in_data(in_data[0]), .out_valid(ova),
    .out_ready(out_ready[0]), .out_data(oda), .err_cnt(erra));

  stream_demux #(.WIDTH(8), .N(3), .ERRW(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy_b),
    .in_sel(in_sel[1]), .in_data(in_data[1]), .out_valid(ovb),
    .out_ready(out_ready[1][2:0]), .out_data(odb), .err_cnt(errb));

  always_comb begin
    ir[0] = rdy_a;           ir[1] = rdy_b;
    ov[0] = ova;             ov[1] = {1'b0, ovb};
    od[0] = oda;             od[1] = {8'h00, odb};
    err[0] = erra;           err[1] = errb;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int drains = 0;
  bit chk_en = 0;

  // Reference state: words accepted but not yet drained, per (dut, channel).
  logic [7:0] exp_q [8][$];
  int         merr  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic model_ready(input int d);
    int s = int'(in_sel[d]);
    if (s >= nch(d)) return 1'b1;
    return (exp_q[d*4+s].size() == 0) || out_ready[d][s];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) exp_q[d*4+k].delete();
        merr[d] = 0;
      end else begin
        logic acc;
        acc = in_valid[d] && model_ready(d);
        for (int k = 0; k < nch(d); k++)
          if (exp_q[d*4+k].size() != 0 && out_ready[d][k]) void'(exp_q[d*4+k].pop_front());
        if (acc) begin
          if (int'(in_sel[d]) < nch(d)) exp_q[d*4+int'(in_sel[d])].push_back(in_data[d]);
          else if (merr[d] < 255) merr[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] ev;
        ev = '0;
        for (int k = 0; k < nch(d); k++) ev[k] = (exp_q[d*4+k].size() != 0);
        chk($sformatf("out_valid[dut%0d]", d), 32'(ov[d]), 32'(ev));
        for (int k = 0; k < nch(d); k++)
          if (ev[k]) chk($sformatf("out_data[dut%0d ch%0d]", d, k), 32'(od[d][k*8 +: 8]),
                         32'(exp_q[d*4+k][0]));
        chk($sformatf("err_cnt[dut%0d]", d), 32'(err[d]), 32'(merr[d]));
        chk($sformatf("in_ready[dut%0d]", d), 32'(ir[d]), 32'(model_ready(d)));
      end
      drains += $countones(ov[0] & out_ready[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_sel[d]    = 2'd0;
      in_data[d]   = 8'h00;
      out_ready[d] = 4'hF;
    end
  endtask

  initial begin
    int d0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    // Reset state, literal expectations.
    chk("reset out_valid", 32'(ova), 32'h0);
    chk("reset out_data", oda, 32'h0);
    chk("reset err_cnt", 32'(erra), 32'h0);
    chk("reset out_valid b", 32'(ovb), 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel[0] = 2'(s);
      #1;
      chk($sformatf("reset in_ready sel%0d", s), 32'(rdy_a), 32'h1);
    end
    in_sel[0] = 2'd0;
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Steering to channel 2.
    in_valid[0] = 1'b1; in_sel[0] = 2'd2; in_data[0] = 8'hA1;
    step();
    in_valid[0] = 1'b0;
    chk("steer out_valid", 32'(ova), 32'h4);
    chk("steer data2", 32'(oda[23:16]), 32'hA1);
    step();

    // Backpressure on channel 1.
    out_ready[0] = 4'b1101;
    in_valid[0] = 1'b1; in_sel[0] = 2'd1; in_data[0] = 8'h11;
    step();
    in_data[0] = 8'h22;
    #1;
    chk("bp in_ready sel1", 32'(rdy_a), 32'h0);
    step();
    chk("bp held data1", 32'(oda[15:8]), 32'h11);
    chk("bp held valid1", 32'(ova[1]), 32'h1);
    in_valid[0] = 1'b0; in_sel[0] = 2'd0;
    #1;
    chk("bp in_ready sel0", 32'(rdy_a), 32'h1);
    in_valid[0] = 1'b1; in_sel[0] = 2'd1; in_data[0] = 8'h22;
    out_ready[0] = 4'hF;
    #1;
    chk("bp in_ready on drain", 32'(rdy_a), 32'h1);
    step();
    in_valid[0] = 1'b0;
    chk("bp data1 after drain", 32'(oda[15:8]), 32'h22);
    chk("bp valid1 after drain", 32'(ova[1]), 32'h1);
    step();

    // Back-to-back throughput.
    d0 = drains;
    for (int i = 0; i < 16; i++) begin
      in_valid[0] = 1'b1; in_sel[0] = 2'(i % 4); in_data[0] = 8'(16 + i * 7);
      #1;
      chk("tput in_ready", 32'(rdy_a), 32'h1);
      step();
    end
    in_valid[0] = 1'b0;
    step();
    chk("tput retired", 32'(drains - d0), 32'd16);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = ($urandom_range(99, 0) < 70);
        in_sel[d]   = 2'($urandom_range(3, 0));
        in_data[d]  = 8'($urandom);
        for (int k = 0; k < 4; k++) out_ready[d][k] = ($urandom_range(99, 0) < 65);
      end
      step();
    end
    idle_inputs();
    step();
    step();

    // Invalid select on the 3-channel instance saturates err_cnt.
    in_valid[1] = 1'b1; in_sel[1] = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_data[1] = 8'(i);
      step();
    end
    in_valid[1] = 1'b0;
    chk("invalid err_cnt sat", 32'(errb), 32'd255);
    chk("invalid out_valid", 32'(ovb), 32'h0);

    // Reset while channels 0 and 3 are full and stalled.
    out_ready[0] = 4'b0110;
    in_valid[0] = 1'b1; in_sel[0] = 2'd0; in_data[0] = 8'h5A;
    step();
    in_sel[0] = 2'd3; in_data[0] = 8'hC3;
    step();
    chk("mid pre-reset valid", 32'(ova), 32'h9);
    in_sel[0] = 2'd1; in_data[0] = 8'h77;
    rst = 1'b1;
    step();
    chk("mid reset out_valid", 32'(ova), 32'h0);
    chk("mid reset out_data", oda, 32'h0);
    rst = 1'b0;
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
